spi_master_core: RTL and testbench

// SPI master shift engine, downstream of the SPI command sequencer. On a one-cycle start it latches
// a 64-bit word and a byte count, then drives a mode-0 (CPOL=0, CPHA=0) frame: cs_n low, N bytes
// MSB-first on mosi, miso captured. It reports busy, busy_reg and a one-cycle finished pulse so the

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_master_core.sv | 140 ++++++++++++++
 tb/tb_spi_master_core.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame sizes, FSM state encodings and the start-bit helper.
// Also used by the SPI command sequencer.
package spi_pkg;

   localparam int SPI_DATA_W = 64;
   localparam int SPI_BYTE_W = 3;
   localparam int SPI_BIT_W  = 6;
   localparam int SPI_CNT_W  = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   // Index of the first (MSB) bit sent for a byte count; 0 wraps to 7 so eight bytes start at 63.
   function automatic logic [SPI_BIT_W-1:0] first_bit(input logic [SPI_BYTE_W-1:0] bytes);
      logic [SPI_BYTE_W-1:0] top;
      top = bytes - 3'd1;
      return {top, 3'b111};
   endfunction

endpackage

// File: rtl/spi_master_core.sv
// Mode-0 SPI master shift engine: latches a word and byte count on start, shifts N bytes
// MSB-first, captures miso on the sclk-high half and reports busy/finished.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | cs_n high, waiting for start
// ST_SETUP | cs_n low, first bit on mosi, sclk low for SETUP_CYC cycles
// ST_SHIFT | two clk per bit: phase 0 sclk low, phase 1 sclk high + sample
// ST_HOLD  | cs_n low after last sclk fall for HOLD_CYC cycles
// ST_GAP   | cs_n high for GAP_CYC cycles, then finished pulse
module spi_master_core
   import spi_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 1,
   parameter int GAP_CYC   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SPI_DATA_W-1:0] data_in,
   input  logic [SPI_BYTE_W-1:0] bite_num,
   input  logic                  miso,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  cs_n,
   output logic                  busy,
   output logic                  busy_reg,
   output logic                  finished,
   output logic [SPI_DATA_W-1:0] rx_data
);

   localparam logic [SPI_CNT_W-1:0] SETUP_LD = SPI_CNT_W'(SETUP_CYC - 1);
   localparam logic [SPI_CNT_W-1:0] HOLD_LD  = SPI_CNT_W'(HOLD_CYC - 1);
   localparam logic [SPI_CNT_W-1:0] GAP_LD   = SPI_CNT_W'(GAP_CYC - 1);

   logic [2:0]            state;
   logic [SPI_CNT_W-1:0]  cnt;
   logic                  phase;
   logic [SPI_BIT_W-1:0]  bit_cnt;
   logic [SPI_BIT_W-1:0]  start_bit;
   logic [SPI_DATA_W-1:0] tx_data;
   logic [SPI_DATA_W-1:0] rx_shift;

   always_comb begin
      start_bit = first_bit(bite_num);
   end

   // Outputs are registered together with the state they belong to, so each value is
   // assigned on the edge that enters the corresponding state or phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         phase    <= 1'b0;
         bit_cnt  <= '0;
         tx_data  <= '0;
         rx_shift <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
         busy     <= 1'b0;
         busy_reg <= 1'b0;
         finished <= 1'b0;
         rx_data  <= '0;
      end else begin
         busy_reg <= busy;
         finished <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_SETUP;
                  tx_data  <= data_in;
                  bit_cnt  <= start_bit;
                  rx_shift <= '0;
                  cnt      <= SETUP_LD;
                  phase    <= 1'b0;
                  cs_n     <= 1'b0;
                  sclk     <= 1'b0;
                  mosi     <= data_in[start_bit];
                  busy     <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (cnt == '0) begin
                  state <= ST_SHIFT;
                  phase <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_SHIFT: begin
               if (!phase) begin
                  phase <= 1'b1;
                  sclk  <= 1'b1;
               end else begin
                  rx_shift <= {rx_shift[SPI_DATA_W-2:0], miso};
                  sclk     <= 1'b0;
                  phase    <= 1'b0;
                  if (bit_cnt == '0) begin
                     state <= ST_HOLD;
                     cnt   <= HOLD_LD;
                     mosi  <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                     mosi    <= tx_data[bit_cnt - 6'd1];
                  end
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  state <= ST_GAP;
                  cnt   <= GAP_LD;
                  cs_n  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  finished <= 1'b1;
                  rx_data  <= rx_shift;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cs_n  <= 1'b1;
               sclk  <= 1'b0;
               mosi  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: cycle-offset frame model compared every negedge,
// plus literal expectations on counts and received data for directed frames.
module tb_spi_master_core;
   import spi_pkg::*;

   localparam int SETUP_CYC = 1;
   localparam int HOLD_CYC  = 1;
   localparam int GAP_CYC   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] data_in = '0;
   logic [2:0]  bite_num = '0;
   logic        loop_mode = 1'b0;
   logic        miso;
   logic        sclk, mosi, cs_n, busy, busy_reg, finished;
   logic [63:0] rx_data;

   int checks = 0;
   int errors = 0;

   assign miso = loop_mode ? mosi : 1'b0;
   always #5 clk = ~clk;

   spi_master_core #(
      .SETUP_CYC(SETUP_CYC),
      .HOLD_CYC (HOLD_CYC),
      .GAP_CYC  (GAP_CYC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .data_in (data_in),
      .bite_num(bite_num),
      .miso    (miso),
      .sclk    (sclk),
      .mosi    (mosi),
      .cs_n    (cs_n),
      .busy    (busy),
      .busy_reg(busy_reg),
      .finished(finished),
      .rx_data (rx_data)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int total(input int n);
      return SETUP_CYC + 16 * n + HOLD_CYC + GAP_CYC;
   endfunction

   function automatic logic [63:0] byte_mask(input int n);
      if (n == 8) return '1;
      return (64'd1 << (8 * n)) - 64'd1;
   endfunction

   // Model: k is the cycle offset inside the current frame (-1 = idle, total = finished cycle).
   int          k = -1;
   int          m_n = 1;
   logic [63:0] m_d = '0;
   logic [63:0] m_rx = '0;
   logic [63:0] rx_hold = '0;
   logic        prev_busy = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k = -1;
         rx_hold = '0;
         prev_busy = 1'b0;
      end else begin
         prev_busy = (k >= 0) && (k < total(m_n));
         if (k == -1 || k == total(m_n)) begin
            if (start) begin
               m_n  = (bite_num == 3'd0) ? 8 : int'(bite_num);
               m_d  = data_in;
               m_rx = loop_mode ? (data_in & byte_mask(m_n)) : 64'd0;
               k    = 0;
            end else begin
               k = -1;
            end
         end else begin
            k++;
         end
         if (k == total(m_n)) rx_hold = m_rx;
      end
   end

   always @(negedge clk) begin
      logic e_cs, e_sclk, e_mosi, e_busy, e_fin;
      int j;
      e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_fin = 1'b0;
      if (!rst && k >= 0) begin
         if (k < SETUP_CYC) begin
            e_cs = 1'b0; e_busy = 1'b1; e_mosi = m_d[8*m_n-1];
         end else if (k < SETUP_CYC + 16*m_n) begin
            j = k - SETUP_CYC;
            e_cs = 1'b0; e_busy = 1'b1;
            e_sclk = (j % 2) == 1;
            e_mosi = m_d[8*m_n-1-j/2];
         end else if (k < SETUP_CYC + 16*m_n + HOLD_CYC) begin
            e_cs = 1'b0; e_busy = 1'b1;
         end else if (k < total(m_n)) begin
            e_busy = 1'b1;
         end else begin
            e_fin = 1'b1;
         end
      end
      check("cs_n", cs_n, e_cs);
      check("sclk", sclk, e_sclk);
      check("mosi", mosi, e_mosi);
      check("busy", busy, e_busy);
      check("busy_reg", busy_reg, prev_busy);
      check("finished", finished, e_fin);
      check("rx_data", rx_data, rx_hold);
   end

   // Activity counters for the literal expectations.
   int   sclk_rises = 0, busy_cnt = 0, fin_cnt = 0, cs_run = 0, cs_high_last = 0;
   logic prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (sclk && !prev_sclk) sclk_rises++;
      prev_sclk = sclk;
      if (busy) busy_cnt++;
      if (finished) fin_cnt++;
      if (cs_n) cs_run++;
      else if (cs_run != 0) begin
         cs_high_last = cs_run;
         cs_run = 0;
      end
   end

   task automatic launch(input logic [63:0] d, input logic [2:0] b, input logic lp);
      sclk_rises = 0; busy_cnt = 0; fin_cnt = 0;
      data_in = d; bite_num = b; loop_mode = lp; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_finished(input string name);
      int t = 0;
      while (!finished && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL %s: finished not seen within 2000 cycles", name);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cs_n"}, cs_n, 64'd1);
      check({tag, "_sclk"}, sclk, 64'd0);
      check({tag, "_mosi"}, mosi, 64'd0);
      check({tag, "_busy"}, busy, 64'd0);
      check({tag, "_busy_reg"}, busy_reg, 64'd0);
      check({tag, "_finished"}, finished, 64'd0);
      check({tag, "_rx_data"}, rx_data, 64'd0);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals(tag);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("rst_init");
      #2 rst = 1'b0;
      @(negedge clk);

      // Two bytes, loopback.
      launch(64'h00f0, 3'd2, 1'b1);
      wait_finished("t2_wait");
      @(negedge clk);
      check("t2_sclk_rises", sclk_rises, 64'd16);
      check("t2_busy_cycles", busy_cnt, 64'd36);
      check("t2_finished_cycles", fin_cnt, 64'd1);
      check("t2_rx_data", rx_data, 64'h00f0);

      // Five bytes, miso held low.
      launch(64'h0000_0004_00ff_ffff, 3'd5, 1'b0);
      wait_finished("t3_wait");
      @(negedge clk);
      check("t3_sclk_rises", sclk_rises, 64'd40);
      check("t3_busy_cycles", busy_cnt, 64'd84);
      check("t3_rx_data", rx_data, 64'd0);

      // Eight bytes, loopback.
      launch(64'h0123_4567_89ab_cdef, 3'd0, 1'b1);
      wait_finished("t4_wait");
      @(negedge clk);
      check("t4_sclk_rises", sclk_rises, 64'd64);
      check("t4_busy_cycles", busy_cnt, 64'd132);
      check("t4_rx_data", rx_data, 64'h0123_4567_89ab_cdef);

      pulse_reset("rst_idle");

      // Ignored start mid-frame, then back-to-back start in the finished cycle.
      launch(64'h0000_0000_0000_a55a, 3'd2, 1'b1);
      repeat (10) @(negedge clk);
      data_in = 64'hdead_beef_cafe_f00d; bite_num = 3'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_finished("t5a_wait");
      check("t5a_rx_data", rx_data, 64'ha55a);
      launch(64'h0000_0000_0000_3cc3, 3'd1, 1'b1);
      @(negedge clk);
      check("t5_cs_high_between", cs_high_last, 64'd3);
      wait_finished("t5b_wait");
      @(negedge clk);
      check("t5b_sclk_rises", sclk_rises, 64'd8);
      check("t5b_rx_data", rx_data, 64'h00c3);

      // Reset during byte 2 of a five-byte frame, then a clean frame.
      launch(64'h0000_0011_2233_4455, 3'd5, 1'b1);
      repeat (20) @(negedge clk);
      pulse_reset("rst_mid");
      launch(64'h0000_0011_2233_4455, 3'd5, 1'b1);
      wait_finished("t6_wait");
      @(negedge clk);
      check("t6_sclk_rises", sclk_rises, 64'd40);
      check("t6_busy_cycles", busy_cnt, 64'd84);
      check("t6_rx_data", rx_data, 64'h0000_0011_2233_4455);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
